transport_rcv: RTL and testbench
================================

Name: transport_rcv

Overview:
- Transport-layer receive block.
- Collects a byte-serial packet from the link layer while `rcvSignal` is high and decodes the header type.
- Packs payload bytes into 16-bit words, then hands the words to the session layer one per cycle once `sessionBusy` is low.
- Single packet buffer; errors are flagged on `dafuq`.

Parameters:
- MAX_BYTES, 16, maximum payload bytes stored per packet.
- WORDS, 8, buffer depth in 16-bit words (MAX_BYTES/2).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rcvSignal  in  1  high while packet bytes are presented, one byte per clock.
- packetIn  in  8  packet byte; the first byte of each burst is the header.
- sessionBusy  in  1  high means the session layer cannot accept words.
- sendingToSession  out  2  type of the word on data: 00 = none, 01 = control, 10 = voice.
- data  out  16  payload word being delivered.
- dafuq  out  1  sticky error flag.

Behaviour:
- Reset (async, active high):
  - State goes to IDLE.
  - sendingToSession=00, data=0, dafuq=0, buffer count=0.
- All outputs are registered.
- Header byte:
  - Bits [7:6] are the type: 01 = control, 10 = voice; 00 and 11 are invalid.
  - Bits [5:0] are ignored.
- Payload packing is big-endian:
  - The first payload byte goes to word[15:8], the next to word[7:0].
  - An odd trailing byte is padded with 0x00 in the low half.
- States: IDLE, RECV, DISCARD, PEND, SEND.
- IDLE:
  - On an edge with rcvSignal=1, latch packetIn as the header and clear the byte count.
  - Valid type -> RECV. Invalid type -> set dafuq and go to DISCARD.
- RECV:
  - While rcvSignal=1, store one byte per edge.
  - Voice stores up to MAX_BYTES; bytes beyond that are dropped and set dafuq.
  - Control stores exactly 2 bytes; extra bytes are silently ignored.
  - On an edge with rcvSignal=0: go to PEND if at least 1 payload byte was stored, else go to IDLE (empty packet, no error).
- DISCARD: ignore bytes until rcvSignal=0, then go to IDLE.
- PEND:
  - Wait while sessionBusy=1.
  - If rcvSignal rises while in PEND, the pending packet is overwritten: dafuq is set and the new header is processed exactly as from IDLE.
- SEND:
  - On each edge with sessionBusy=0, drive sendingToSession=type and data=next word.
  - Word count = ceil(bytes/2); control packets always yield 1 word.
  - On an edge with sessionBusy=1, drive sendingToSession=00, keep data, and pause the read pointer.
  - After the last word is presented for one cycle, the next edge drives sendingToSession=00 and data=0 and returns to IDLE.
  - rcvSignal is ignored while in SEND; the link must not send during delivery. Bytes arriving then are lost and set dafuq.
- Latency: the first word appears on the second edge after rcvSignal is sampled low, given sessionBusy=0 (PEND->SEND, then first word).
- dafuq is cleared only by reset.
- Reset during any state aborts the operation immediately; the buffer contents become don't-care.

Decomposition:
- Package transport_pkg holds:
  - type codes TYPE_NONE=2'b00, TYPE_CTRL=2'b01, TYPE_VOICE=2'b10;
  - the state enum;
  - MAX_BYTES / WORDS constants.
- One natural sub-module, rx_word_buf: a WORDS x 16 register file with byte-lane write (high/low), word read pointer and word count.

Test Plan:
- Voice: header 0x80, then bytes 04,05,06,07,08,09,10,11,12,13,14,15,16,17,FF with sessionBusy=0.
  - Expect 8 consecutive words 0x0405, 0x0607, 0x0809, 0x1011, 0x1213, 0x1415, 0x1617, 0xFF00, each with sendingToSession=10; then 00 and data=0; dafuq=0.
- Control overwrite: voice packet as above, held with sessionBusy=1; then header 0x40 followed by 15 bytes of 0x02; release sessionBusy.
  - Expect a single word 0x0202 with sendingToSession=01 and dafuq=1 (overwrite).
- Invalid header: header 0x00 or 0xC0 plus 3 bytes.
  - Expect no delivery (sendingToSession stays 00), dafuq=1, state returns to IDLE.
- Overflow: header 0x80 plus 18 bytes 01..12 (hex).
  - Expect 8 words 0x0102..0x0F10, dafuq=1.
- Backpressure: voice packet with 4 bytes AA,BB,CC,DD; toggle sessionBusy high for 2 cycles after the first word.
  - Expect 0xAABB, then 2 cycles of sendingToSession=00 with data held at 0xAABB, then 0xCCDD.
- Reset: assert reset mid-RECV and mid-SEND.
  - Expect outputs 00 / 0 / dafuq=0 immediately (asynchronous), and the next packet is received normally.

Source files
------------

// File: rtl/transport_pkg.sv
// Shared types and constants for the transport-layer receive path.
package transport_pkg;

  localparam int MAX_BYTES = 16;
  localparam int WORDS     = MAX_BYTES / 2;

  localparam logic [1:0] TYPE_NONE  = 2'b00;
  localparam logic [1:0] TYPE_CTRL  = 2'b01;
  localparam logic [1:0] TYPE_VOICE = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    DISCARD,
    PEND,
    SEND
  } state_t;

  // Header types 00 and 11 are not defined on the link.
  function automatic logic type_valid(input logic [1:0] t);
    return (t == TYPE_CTRL) || (t == TYPE_VOICE);
  endfunction

endpackage

// File: rtl/rx_word_buf.sv
// Single-packet word buffer: bytes are packed big-endian into 16-bit words
// and read back one word at a time through a read pointer.
module rx_word_buf #(
  parameter int WORDS  = 8,
  parameter int BCNT_W = 5,
  parameter int WPTR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [7:0]        wr_byte,
  input  logic              rd_adv,
  output logic [15:0]       rd_word,
  output logic [BCNT_W-1:0] byte_cnt,
  output logic [WPTR_W-1:0] word_cnt,
  output logic              rd_done
);

  localparam int AW = $clog2(WORDS);

  logic [15:0]       mem [WORDS];
  logic [WPTR_W-1:0] rd_ptr;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;

  assign wr_idx   = byte_cnt[AW:1];
  assign rd_idx   = rd_ptr[AW-1:0];
  assign rd_word  = mem[rd_idx];
  assign word_cnt = WPTR_W'((byte_cnt + BCNT_W'(1)) >> 1);
  assign rd_done  = (rd_ptr == word_cnt);

  // Byte-lane write; an even byte clears the low lane so an odd tail pads with 0x00.
  // NOTE: the storage array has no reset; the byte count qualifies which
  // words are meaningful, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (!byte_cnt[0]) mem[wr_idx] <= {wr_byte, 8'h00};
      else              mem[wr_idx][7:0] <= wr_byte;
    end
  end

  // Write byte count and read word pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= '0;
      rd_ptr   <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      rd_ptr   <= '0;
    end else begin
      if (wr_en)  byte_cnt <= byte_cnt + BCNT_W'(1);
      if (rd_adv) rd_ptr   <= rd_ptr + WPTR_W'(1);
    end
  end

endmodule

// File: rtl/transport_rcv.sv
// Transport-layer receive block: collects a byte-serial packet, decodes the
// header type and delivers packed 16-bit words to the session layer.
module transport_rcv #(
  parameter int MAX_BYTES = 16,
  parameter int WORDS     = MAX_BYTES / 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rcvSignal,
  input  logic [7:0]  packetIn,
  input  logic        sessionBusy,
  output logic [1:0]  sendingToSession,
  output logic [15:0] data,
  output logic        dafuq
);

  import transport_pkg::*;

  localparam int BCNT_W = $clog2(MAX_BYTES + 1);
  localparam int WPTR_W = $clog2(WORDS + 1);

  state_t            state;
  logic [1:0]        type_q;
  logic              buf_clear;
  logic              buf_wr;
  logic              rd_adv;
  logic              room;
  logic [15:0]       rd_word;
  logic [BCNT_W-1:0] byte_cnt;
  logic [WPTR_W-1:0] word_cnt;
  logic              rd_done;

  rx_word_buf #(
    .WORDS  (WORDS),
    .BCNT_W (BCNT_W),
    .WPTR_W (WPTR_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .clear    (buf_clear),
    .wr_en    (buf_wr),
    .wr_byte  (packetIn),
    .rd_adv   (rd_adv),
    .rd_word  (rd_word),
    .byte_cnt (byte_cnt),
    .word_cnt (word_cnt),
    .rd_done  (rd_done)
  );

  // Buffer control: a new header empties the buffer, payload bytes fill it
  // up to the per-type limit, and each delivered word advances the reader.
  // NOTE: every signal gets a value on every path so no latch is inferred.
  always_comb begin
    room      = (type_q == TYPE_VOICE) ? (byte_cnt < BCNT_W'(MAX_BYTES))
                                       : (byte_cnt < BCNT_W'(2));
    buf_clear = ((state == IDLE) || (state == PEND)) && rcvSignal;
    buf_wr    = (state == RECV) && rcvSignal && room;
    rd_adv    = (state == SEND) && !sessionBusy && !rd_done;
  end

  // Receive / deliver FSM with registered outputs.
  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      type_q           <= TYPE_NONE;
      sendingToSession <= TYPE_NONE;
      data             <= '0;
      dafuq            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rcvSignal) begin
            type_q <= packetIn[7:6];
            if (type_valid(packetIn[7:6])) begin
              state <= RECV;
            end else begin
              dafuq <= 1'b1;
              state <= DISCARD;
            end
          end
        end
        RECV: begin
          if (rcvSignal) begin
            // Voice overflow is an error; extra control bytes are not.
            if ((type_q == TYPE_VOICE) && !room) dafuq <= 1'b1;
          end else begin
            state <= (byte_cnt != '0) ? PEND : IDLE;
          end
        end
        DISCARD: begin
          if (!rcvSignal) state <= IDLE;
        end
        PEND: begin
          if (rcvSignal) begin
            // A new packet overwrites the one still waiting for delivery.
            dafuq  <= 1'b1;
            type_q <= packetIn[7:6];
            state  <= type_valid(packetIn[7:6]) ? RECV : DISCARD;
          end else if (!sessionBusy) begin
            state <= SEND;
          end
        end
        SEND: begin
          if (rcvSignal) dafuq <= 1'b1;
          if (rd_done) begin
            sendingToSession <= TYPE_NONE;
            data             <= '0;
            state            <= IDLE;
          end else if (sessionBusy) begin
            sendingToSession <= TYPE_NONE;
          end else begin
            sendingToSession <= type_q;
            data             <= rd_word;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transport_rcv.sv
// Directed bench for transport_rcv with a queue-based scoreboard.
module tb_transport_rcv;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rcvSignal = 1'b0;
  logic [7:0]  packetIn = 8'h00;
  logic        sessionBusy = 1'b0;
  logic [1:0]  sendingToSession;
  logic [15:0] data;
  logic        dafuq;

  typedef struct {
    logic [1:0]  t;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  logic [7:0] vb [15] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11,
                          8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hFF};

  transport_rcv dut (
    .clk              (clk),
    .reset            (reset),
    .rcvSignal        (rcvSignal),
    .packetIn         (packetIn),
    .sessionBusy      (sessionBusy),
    .sendingToSession (sendingToSession),
    .data             (data),
    .dafuq            (dafuq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Monitor: every presented word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && sendingToSession != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", {14'b0, sendingToSession, data}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("word", {14'b0, sendingToSession, data}, {14'b0, mon_e.t, mon_e.d});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rcvSignal = 1'b1;
    packetIn  = b;
    tick();
  endtask

  task automatic stop_burst();
    rcvSignal = 1'b0;
    packetIn  = 8'h00;
    tick();
  endtask

  task automatic expect_word(input logic [1:0] t, input logic [15:0] d);
    exp_t e;
    e.t = t;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    tick();
    check({name, "_end_type"}, 32'(sendingToSession), 32'h0);
    check({name, "_end_data"}, 32'(data), 32'h0);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    rcvSignal   = 1'b0;
    packetIn    = 8'h00;
    sessionBusy = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {13'b0, dafuq, sendingToSession, data}, 32'h0);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Voice packet, 15 bytes, odd tail padded.
    do_reset();
    put(8'h80);
    foreach (vb[i]) put(vb[i]);
    expect_word(2'b10, 16'h0405); expect_word(2'b10, 16'h0607);
    expect_word(2'b10, 16'h0809); expect_word(2'b10, 16'h1011);
    expect_word(2'b10, 16'h1213); expect_word(2'b10, 16'h1415);
    expect_word(2'b10, 16'h1617); expect_word(2'b10, 16'hFF00);
    stop_burst();
    drain("voice");
    check("voice_dafuq", 32'(dafuq), 32'h0);

    // Control packet overwrites a pending voice packet.
    do_reset();
    sessionBusy = 1'b1;
    put(8'h80);
    foreach (vb[i]) put(vb[i]);
    stop_burst();
    repeat (3) tick();
    put(8'h40);
    repeat (15) put(8'h02);
    stop_burst();
    expect_word(2'b01, 16'h0202);
    sessionBusy = 1'b0;
    drain("ctrl");
    check("ctrl_dafuq", 32'(dafuq), 32'h1);

    // Invalid headers are discarded, then a valid packet still goes through.
    do_reset();
    put(8'h00);
    repeat (3) put(8'h01);
    stop_burst();
    repeat (4) tick();
    check("inv00_dafuq", 32'(dafuq), 32'h1);
    check("inv00_type", 32'(sendingToSession), 32'h0);
    put(8'hC0);
    repeat (3) put(8'h01);
    stop_burst();
    repeat (4) tick();
    check("invC0_type", 32'(sendingToSession), 32'h0);
    put(8'h80);
    put(8'h12);
    put(8'h34);
    expect_word(2'b10, 16'h1234);
    stop_burst();
    drain("after_invalid");

    // Voice overflow: 18 bytes, only 16 kept.
    do_reset();
    put(8'h80);
    for (int i = 1; i <= 18; i++) put(8'(i));
    for (int k = 0; k < 8; k++) expect_word(2'b10, {8'(2*k+1), 8'(2*k+2)});
    stop_burst();
    drain("overflow");
    check("overflow_dafuq", 32'(dafuq), 32'h1);

    // Backpressure after the first word.
    do_reset();
    put(8'h80);
    put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
    expect_word(2'b10, 16'hAABB);
    expect_word(2'b10, 16'hCCDD);
    stop_burst();
    tick();
    tick();
    sessionBusy = 1'b1;
    tick();
    check("bp1_type", 32'(sendingToSession), 32'h0);
    check("bp1_data", 32'(data), 32'h0000AABB);
    tick();
    check("bp2_type", 32'(sendingToSession), 32'h0);
    check("bp2_data", 32'(data), 32'h0000AABB);
    sessionBusy = 1'b0;
    drain("bp");

    // Asynchronous reset mid-RECV (with dafuq already set).
    do_reset();
    put(8'hC0);
    stop_burst();
    put(8'h80);
    put(8'h11);
    put(8'h22);
    #2 reset = 1'b1;
    #1;
    check("rst_recv", {13'b0, dafuq, sendingToSession, data}, 32'h0);
    #2 reset = 1'b0;
    rcvSignal = 1'b0;
    tick();

    // Asynchronous reset mid-SEND, then a normal packet.
    put(8'h80);
    put(8'hA1); put(8'hA2); put(8'hB1); put(8'hB2);
    expect_word(2'b10, 16'hA1A2);
    stop_burst();
    tick();
    tick();
    @(negedge clk);
    #1;
    check("send_before_rst", 32'(exp_q.size()), 32'h0);
    reset = 1'b1;
    #1;
    check("rst_send", {13'b0, dafuq, sendingToSession, data}, 32'h0);
    #2 reset = 1'b0;
    exp_q.delete();
    tick();
    put(8'h40);
    put(8'h5A);
    put(8'h5B);
    expect_word(2'b01, 16'h5A5B);
    stop_burst();
    drain("post_reset");
    check("post_reset_dafuq", 32'(dafuq), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
